// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder family: mode constants, strobe FSM states
// and a reusable one-hot helper.
package decoder_pkg;

  localparam int DEC_MODE_LEVEL = 0;
  localparam int DEC_MODE_PULSE = 1;

  typedef enum logic [0:0] {
    DEC_IDLE  = 1'b0,
    DEC_DRIVE = 1'b1
  } dec_state_e;

  // Widest supported decoder is 6 -> 64; callers truncate to their own width.
  function automatic logic [63:0] onehot_of(input logic [5:0] sel);
    logic [63:0] vec;
    vec      = 64'd0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2^N one-hot decode with enable; all-zero when disabled.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] onehot
);

  localparam int OUT_W = 2**SEL_W;

  // decode the select into a single set bit, gated by enable
  always_comb begin
    if (en) begin
      onehot = OUT_W'(onehot_of(6'(sel)));
    end else begin
      onehot = {OUT_W{1'b0}};
    end
  end

endmodule

// File: rtl/decoder_strobe_n.sv
// Registered one-hot strobe decoder with valid/ready intake, optional active-low
// polarity, and a level or fixed-length pulse output mode.
module decoder_strobe_n
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int MODE       = 0,
  parameter int PULSE_LEN  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] y,
  output logic                  busy,
  output logic                  done
);

  localparam int               OUT_W    = 2**SEL_W;
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [7:0]       CNT_LOAD = 8'(PULSE_LEN - 1);
  localparam bit               IS_PULSE = (MODE == DEC_MODE_PULSE);

  logic [OUT_W-1:0] onehot_s;
  logic [OUT_W-1:0] pattern_s;
  logic [OUT_W-1:0] y_next_s;
  logic [OUT_W-1:0] y_r;
  dec_state_e       state_r;
  dec_state_e       state_next_s;
  logic [7:0]       cnt_r;
  logic [7:0]       cnt_next_s;
  logic             busy_r;
  logic             busy_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             ready_s;
  logic             xfer_s;

  decoder_onehot #(.SEL_W(SEL_W)) u_onehot (
    .sel    (sel),
    .en     (en),
    .onehot (onehot_s)
  );

  // XOR with the inactive pattern applies polarity; en=0 yields the inactive pattern
  assign pattern_s = onehot_s ^ INACTIVE;

  // intake readiness depends only on reset, state and the pulse counter
  always_comb begin
    if (rst) begin
      ready_s = 1'b0;
    end else if (!IS_PULSE) begin
      ready_s = 1'b1;
    end else if (state_r == DEC_IDLE) begin
      ready_s = 1'b1;
    end else if (cnt_r == 8'd0) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign in_ready = ready_s;
  assign xfer_s   = in_valid && ready_s;

  // next-state, counter and output pattern selection
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    y_next_s     = y_r;
    if (!IS_PULSE) begin
      state_next_s = DEC_IDLE;
      cnt_next_s   = 8'd0;
      if (xfer_s) begin
        y_next_s = pattern_s;
      end else begin
        y_next_s = y_r;
      end
    end else begin
      case (state_r)
        DEC_IDLE: begin
          if (xfer_s && en) begin
            state_next_s = DEC_DRIVE;
            cnt_next_s   = CNT_LOAD;
            y_next_s     = pattern_s;
          end else begin
            state_next_s = DEC_IDLE;
            cnt_next_s   = 8'd0;
            y_next_s     = INACTIVE;
          end
        end
        DEC_DRIVE: begin
          if (cnt_r != 8'd0) begin
            state_next_s = DEC_DRIVE;
            cnt_next_s   = cnt_r - 8'd1;
            y_next_s     = y_r;
          end else if (xfer_s && en) begin
            // reload in the final cycle: new strobe follows with no inactive gap
            state_next_s = DEC_DRIVE;
            cnt_next_s   = CNT_LOAD;
            y_next_s     = pattern_s;
          end else begin
            state_next_s = DEC_IDLE;
            cnt_next_s   = 8'd0;
            y_next_s     = INACTIVE;
          end
        end
        default: begin
          state_next_s = DEC_IDLE;
          cnt_next_s   = 8'd0;
          y_next_s     = INACTIVE;
        end
      endcase
    end
    busy_next_s = IS_PULSE && (state_next_s == DEC_DRIVE);
    done_next_s = busy_next_s && (cnt_next_s == 8'd0);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DEC_IDLE;
      cnt_r   <= 8'd0;
      y_r     <= INACTIVE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      y_r     <= y_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  assign y    = y_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_decoder_strobe_n.sv
// Scoreboard bench for decoder_strobe_n: five configured instances, directed
// per-cycle vectors, expectations queued by stimulus and checked by a monitor.
module tb_decoder_strobe_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int drain_wait = 0;
  logic stim_done = 1'b0;

  logic       rst_a [5];
  logic       vld_a [5];
  logic       en_a  [5];
  logic [2:0] sel_a [5];

  logic [7:0] y_m    [5];
  logic       rdy_m  [5];
  logic       busy_m [5];
  logic       done_m [5];

  logic [3:0] y0, y2, y3, y4;
  logic [7:0] y1;

  // d0: LEVEL SEL_W=2
  decoder_strobe_n #(.SEL_W(2), .MODE(0), .PULSE_LEN(1), .ACTIVE_LOW(0)) u_lvl (
    .clk(clk), .rst(rst_a[0]), .in_valid(vld_a[0]), .in_ready(rdy_m[0]),
    .sel(sel_a[0][1:0]), .en(en_a[0]), .y(y0), .busy(busy_m[0]), .done(done_m[0]));
  // d1: PULSE SEL_W=3 LEN=3
  decoder_strobe_n #(.SEL_W(3), .MODE(1), .PULSE_LEN(3), .ACTIVE_LOW(0)) u_p3 (
    .clk(clk), .rst(rst_a[1]), .in_valid(vld_a[1]), .in_ready(rdy_m[1]),
    .sel(sel_a[1]), .en(en_a[1]), .y(y1), .busy(busy_m[1]), .done(done_m[1]));
  // d2: PULSE SEL_W=2 LEN=2
  decoder_strobe_n #(.SEL_W(2), .MODE(1), .PULSE_LEN(2), .ACTIVE_LOW(0)) u_p2 (
    .clk(clk), .rst(rst_a[2]), .in_valid(vld_a[2]), .in_ready(rdy_m[2]),
    .sel(sel_a[2][1:0]), .en(en_a[2]), .y(y2), .busy(busy_m[2]), .done(done_m[2]));
  // d3: PULSE SEL_W=2 LEN=5
  decoder_strobe_n #(.SEL_W(2), .MODE(1), .PULSE_LEN(5), .ACTIVE_LOW(0)) u_p5 (
    .clk(clk), .rst(rst_a[3]), .in_valid(vld_a[3]), .in_ready(rdy_m[3]),
    .sel(sel_a[3][1:0]), .en(en_a[3]), .y(y3), .busy(busy_m[3]), .done(done_m[3]));
  // d4: LEVEL SEL_W=2 active-low
  decoder_strobe_n #(.SEL_W(2), .MODE(0), .PULSE_LEN(1), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst(rst_a[4]), .in_valid(vld_a[4]), .in_ready(rdy_m[4]),
    .sel(sel_a[4][1:0]), .en(en_a[4]), .y(y4), .busy(busy_m[4]), .done(done_m[4]));

  assign y_m[0] = {4'd0, y0};
  assign y_m[1] = y1;
  assign y_m[2] = {4'd0, y2};
  assign y_m[3] = {4'd0, y3};
  assign y_m[4] = {4'd0, y4};

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t q[$];

  // Drive one DUT for the current cycle and queue what it must show this cycle.
  task automatic step(input int d, input logic r, input logic v, input logic [2:0] s,
                      input logic e, input logic [7:0] ey, input logic eb,
                      input logic ed, input logic er, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_a[d] = r;
    vld_a[d] = v;
    sel_a[d] = s;
    en_a[d]  = e;
    x.cyc  = cyc;
    x.dut  = d;
    x.y    = ey;
    x.busy = eb;
    x.done = ed;
    x.rdy  = er;
    x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: compare every due expectation on the falling edge, then finish once drained.
  always @(negedge clk) begin : monitor
    exp_t x;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      checks++;
      if (x.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                 x.name, x.cyc, cyc);
      end else if ({y_m[x.dut], busy_m[x.dut], done_m[x.dut], rdy_m[x.dut]} !==
                   {x.y, x.busy, x.done, x.rdy}) begin
        errors++;
        $display("FAIL %s (dut %0d cyc %0d): got y=%h busy=%b done=%b rdy=%b, want y=%h busy=%b done=%b rdy=%b",
                 x.name, x.dut, cyc, y_m[x.dut], busy_m[x.dut], done_m[x.dut], rdy_m[x.dut],
                 x.y, x.busy, x.done, x.rdy);
      end
    end
    if (stim_done) begin
      drain_wait++;
      if (q.size() == 0 || drain_wait > 10) begin
        if (q.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL drain: %0d expectations left unchecked", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      rst_a[i] = 1'b1;
      vld_a[i] = 1'b0;
      en_a[i]  = 1'b0;
      sel_a[i] = 3'd0;
    end

    // reset state of every instance
    step(0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rst_lvl");
    step(1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rst_p3");
    step(2, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rst_p2");
    step(3, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "rst_p5");
    step(4, 1'b1, 1'b0, 3'd0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, "rst_al");

    // LEVEL: consecutive codes, then an en=0 transfer clears the output
    step(0, 1'b0, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "lvl_c0");
    step(0, 1'b0, 1'b1, 3'd1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, "lvl_c1");
    step(0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, "lvl_c2");
    step(0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, "lvl_c3");
    step(0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, "lvl_c4");
    step(0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, "lvl_hold");
    step(0, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "lvl_en0");

    // PULSE LEN=3: sel=5, held sel=2 accepted only in the done cycle
    step(1, 1'b0, 1'b1, 3'd5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "p3_c0");
    step(1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, "p3_c1");
    step(1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, "p3_c2");
    step(1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h20, 1'b1, 1'b1, 1'b1, "p3_c3");
    step(1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, "p3_c4");
    step(1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, "p3_c5");
    step(1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b1, "p3_c6");
    step(1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "p3_c7");

    // PULSE LEN=2: back-to-back, then en=0 transfer, then sel=2
    step(2, 1'b0, 1'b1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "p2_c0");
    step(2, 1'b0, 1'b0, 3'd0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, "p2_c1");
    step(2, 1'b0, 1'b1, 3'd3, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, "p2_c2");
    step(2, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, "p2_c3");
    step(2, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b1, 1'b1, "p2_c4");
    step(2, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "p2_c5");
    step(2, 1'b0, 1'b1, 3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "p2_en0");
    step(2, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, "p2_c7");
    step(2, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 1'b1, "p2_c8");
    step(2, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "p2_c9");

    // PULSE LEN=5: reset in the 2nd drive cycle, then a full pulse
    step(3, 1'b0, 1'b1, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "p5_c0");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, "p5_c1");
    step(3, 1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, "p5_rst");
    step(3, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "p5_abort");
    step(3, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, "p5_resume");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, "p5_d1");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, "p5_d2");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, "p5_d3");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0, "p5_d4");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b1, 1'b1, 1'b1, "p5_d5");
    step(3, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "p5_idle");

    // ACTIVE_LOW LEVEL
    step(4, 1'b0, 1'b1, 3'd2, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, "al_c0");
    step(4, 1'b0, 1'b1, 3'd0, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b1, "al_sel2");
    step(4, 1'b0, 1'b1, 3'd3, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, "al_en0");
    step(4, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, "al_sel3");

    stim_done = 1'b1;
  end

endmodule
